tlb_query_engine: RTL and testbench
===================================

// Module: tlb_query_engine
// PURPOSE
//  Read-side companion to the TLB write path: executes TLBR (read entry) and TLBP (probe) for CP0.
//  TLBR returns an entry in the same 75-bit {entry,index} layout CP0 uses to write it.
//  TLBP scans entries one per cycle for a VPN2 match and returns Index/P to CP0.
//  Sits between CP0 and the TLB entry array via a dedicated combinational read port.
// PARAMETERS
//  NUM_ENTRIES  16  TLB entries scanned/addressable
//  IDX_W        4   index width, log2(NUM_ENTRIES)
//  VPN2_W       19  VPN2 key width (entry bits [70:52])
//  ENTRY_W      71  {vpn2[70:52],pfn1[51:28],d1[27],v1[26],pfn0[25:2],d0[1],v0[0]}
// PORTS
//  clk          in   1        clock; all logic on posedge
//  rst          in   1        synchronous reset, active-high
//  op_tlbp      in   1        start probe (sampled only in IDLE)
//  op_tlbr      in   1        start read (sampled only in IDLE)
//  index_in     in   IDX_W    CP0 Index for TLBR
//  probe_vpn2   in   VPN2_W   CP0 EntryHi VPN2 for TLBP
//  tlbwi        in   1        TLB write strobe (coherency restart)
//  rd_idx       out  IDX_W    entry-array read address
//  rd_entry     in   ENTRY_W  entry-array data at rd_idx (combinational, same cycle)
//  busy         out  1        op in progress; CP0/pipeline stalls while high
//  done         out  1        one-cycle pulse: results valid
//  tlbr_data    out  ENTRY_W+IDX_W  {entry,index} read result
//  probe_p      out  1        1 = probe miss (CP0 Index.P)
//  probe_index  out  IDX_W    lowest matching index on hit
// BEHAVIOUR
//  Reset: all outputs 0 (busy, done, rd_idx, tlbr_data, probe_p, probe_index); state IDLE.
//  States: IDLE, READ, SCAN, DONE.
//  IDLE: op_tlbp=1 -> latch probe_vpn2, rd_idx<=0, SCAN. Else op_tlbr=1 -> latch index_in into rd_idx, READ.
//   Both ops high in the same cycle: TLBP wins; TLBR is dropped.
//  busy=1 in READ/SCAN/DONE. Op requests in non-IDLE states are ignored (no queuing).
//  READ (1 cycle): tlbr_data<={rd_entry,rd_idx} -> DONE. Latency: op at T, done at T+2.
//  SCAN: each cycle compare rd_entry[70:52]==latched key (V/D bits ignored).
//   Hit: probe_index<=rd_idx, probe_p<=0 -> DONE.
//   Miss with rd_idx==NUM_ENTRIES-1: probe_p<=1, probe_index unchanged -> DONE.
//   Otherwise rd_idx<=rd_idx+1. No wrap: scan ends at the last index.
//   Latency: hit at k -> done at T+2+k; full miss -> done at T+NUM_ENTRIES+1.
//  Multiple matches: lowest index reported (early stop).
//  DONE (1 cycle): done=1 -> IDLE. busy is still 1 in DONE and drops the next cycle.
//  tlbwi in READ/SCAN: discard the cycle's compare/capture.
//   READ re-executes the same index; SCAN restarts at rd_idx=0 with the latched key.
//   Results therefore reflect the post-write array. tlbwi in IDLE/DONE: no effect.
//  Results not updated by an op hold their previous values:
//   TLBR leaves probe_*; TLBP leaves tlbr_data.
//  rst mid-op: abort next edge; all outputs 0; no done pulse.
// STRUCTURE
//  Shared package tlb_pkg:
//   constants NUM_ENTRIES, IDX_W, VPN2_W, ENTRY_W
//   field offsets VPN2_HI/LO etc., matching the CP0 config layout
//   typedef struct packed tlb_entry_t
//   typedef enum tlbq_state_e {IDLE,READ,SCAN,DONE}
//  Single module; no sub-module needed. The VPN2 compare is inline.
//  Entry array is instantiated by the TLB, which adds the rd_idx/rd_entry port.
// TESTING
//  1. Entry 5 loaded, op_tlbr with index_in=5 at T -> done@T+2, tlbr_data=={entry5,4'd5}, busy T+1..T+2.
//  2. vpn2 0x12345 in entries 3 and 9, op_tlbp -> done@T+5, probe_p=0, probe_index=3.
//  3. No matching entry, op_tlbp -> done@T+17, probe_p=1, probe_index keeps its prior value.
//  4. op_tlbp and op_tlbr high together -> probe runs, tlbr_data unchanged; re-pulsing ops while busy has no effect.
//  5. tlbwi writes key 0x00ABC into entry 2 when rd_idx=6 -> scan restarts at 0, probe_index=2, done 3 cycles after restart.
//  6. rst asserted during SCAN at rd_idx=7 -> next cycle all outputs 0, IDLE, no done pulse; a new op then works normally.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared TLB definitions: geometry, the CP0 entry layout and the query-engine state encoding.
package tlb_pkg;

  localparam int NUM_ENTRIES = 16;
  localparam int IDX_W       = 4;
  localparam int VPN2_W      = 19;
  localparam int ENTRY_W     = 71;

  // Bit positions inside an entry, identical to the layout CP0 writes.
  localparam int VPN2_HI = 70;
  localparam int VPN2_LO = 52;
  localparam int PFN1_HI = 51;
  localparam int PFN1_LO = 28;
  localparam int D1_BIT  = 27;
  localparam int V1_BIT  = 26;
  localparam int PFN0_HI = 25;
  localparam int PFN0_LO = 2;
  localparam int D0_BIT  = 1;
  localparam int V0_BIT  = 0;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [23:0]       pfn1;
    logic              d1;
    logic              v1;
    logic [23:0]       pfn0;
    logic              d0;
    logic              v0;
  } tlb_entry_t;

  typedef enum logic [1:0] {IDLE, READ, SCAN, DONE} tlbq_state_e;

endpackage

// File: rtl/tlb_query_engine.sv
// TLBR/TLBP execution for CP0: single-cycle entry read, or a linear VPN2 probe
// over the entry array through its combinational read port.
module tlb_query_engine
  import tlb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_tlbp,
  input  logic                     op_tlbr,
  input  logic [IDX_W-1:0]         index_in,
  input  logic [VPN2_W-1:0]        probe_vpn2,
  input  logic                     tlbwi,
  output logic [IDX_W-1:0]         rd_idx,
  input  logic [ENTRY_W-1:0]       rd_entry,
  output logic                     busy,
  output logic                     done,
  output logic [ENTRY_W+IDX_W-1:0] tlbr_data,
  output logic                     probe_p,
  output logic [IDX_W-1:0]         probe_index
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_READ = READ;
  localparam logic [1:0] S_SCAN = SCAN;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  logic [1:0]        state;
  logic [VPN2_W-1:0] probeKey;
  logic              keyHit;

  // Only the VPN2 field takes part in the match; V/D bits are deliberately ignored.
  assign keyHit = (rd_entry[VPN2_HI:VPN2_LO] == probeKey);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // NOTE: all state here uses <= so every branch sees the pre-edge values of rd_idx/state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      probeKey    <= '0;
      rd_idx      <= '0;
      tlbr_data   <= '0;
      probe_p     <= 1'b0;
      probe_index <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_tlbp) begin
            probeKey <= probe_vpn2;
            rd_idx   <= '0;
            state    <= S_SCAN;
          end else if (op_tlbr) begin
            rd_idx <= index_in;
            state  <= S_READ;
          end
        end
        S_READ: begin
          // A concurrent write may have changed this entry; retry on the next cycle.
          if (!tlbwi) begin
            tlbr_data <= {rd_entry, rd_idx};
            state     <= S_DONE;
          end
        end
        S_SCAN: begin
          if (tlbwi) begin
            rd_idx <= '0;
          end else if (keyHit) begin
            probe_index <= rd_idx;
            probe_p     <= 1'b0;
            state       <= S_DONE;
          end else if (rd_idx == LAST_IDX) begin
            probe_p <= 1'b1;
            state   <= S_DONE;
          end else begin
            rd_idx <= rd_idx + IDX_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_query_engine.sv
// Self-checking bench for tlb_query_engine: directed table, multi-cycle corner
// sequences and randomized ops against a behavioural array model.
module tb_tlb_query_engine;
  import tlb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_tlbp, op_tlbr, tlbwi;
  logic [3:0]  index_in;
  logic [18:0] probe_vpn2;
  logic [3:0]  rd_idx;
  logic [70:0] rd_entry;
  logic        busy, done, probe_p;
  logic [74:0] tlbr_data;
  logic [3:0]  probe_index;

  logic [70:0] mem [16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rd_entry = mem[rd_idx];

  tlb_query_engine dut (
    .clk(clk), .rst(rst), .op_tlbp(op_tlbp), .op_tlbr(op_tlbr),
    .index_in(index_in), .probe_vpn2(probe_vpn2), .tlbwi(tlbwi),
    .rd_idx(rd_idx), .rd_entry(rd_entry), .busy(busy), .done(done),
    .tlbr_data(tlbr_data), .probe_p(probe_p), .probe_index(probe_index)
  );

  typedef struct {
    logic        doP;
    logic        doR;
    logic [3:0]  idx;
    logic [18:0] key;
    int          lat;
    logic [74:0] expTlbr;
    logic        expP;
    logic [3:0]  expPidx;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [70:0] mkEntry(input int i, input logic [18:0] vpn);
    tlb_entry_t e;
    logic [3:0] b;
    b      = 4'(i);
    e.vpn2 = vpn;
    e.pfn1 = {20'hA0000, b};
    e.d1   = b[0];
    e.v1   = b[1];
    e.pfn0 = {20'h0B000, b};
    e.d0   = b[2];
    e.v0   = b[3];
    return e;
  endfunction

  task automatic startOp(input logic doP, input logic doR, input logic [3:0] idx, input logic [18:0] key);
    @(negedge clk);
    op_tlbp    = doP;
    op_tlbr    = doR;
    index_in   = idx;
    probe_vpn2 = key;
    @(posedge clk);
    #1;
    op_tlbp = 1'b0;
    op_tlbr = 1'b0;
  endtask

  // Counts sampled cycles after the launch cycle until done; can hold both op
  // lines high over [pokeFrom, pokeTo) while the engine is busy.
  task automatic waitDone(input int startN, input int pokeFrom, input int pokeTo, output int lat);
    bit busyOk;
    busyOk = 1'b1;
    lat    = -1;
    for (int n = startN + 1; n <= startN + 40; n++) begin
      @(negedge clk);
      if (busy !== 1'b1) busyOk = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (n >= pokeFrom && n < pokeTo) begin
        op_tlbp    = 1'b1;
        op_tlbr    = 1'b1;
        index_in   = 4'd5;
        probe_vpn2 = 19'h12345;
      end else begin
        op_tlbp = 1'b0;
        op_tlbr = 1'b0;
      end
    end
    op_tlbp = 1'b0;
    op_tlbr = 1'b0;
    check("busy_held", {127'd0, busyOk}, 128'd1);
  endtask

  task automatic checkIdleAfter();
    @(negedge clk);
    check("busy_drop", {127'd0, busy}, 128'd0);
    check("done_single", {127'd0, done}, 128'd0);
  endtask

  task automatic runOp(input logic doP, input logic doR, input logic [3:0] idx,
                       input logic [18:0] key, output int lat);
    startOp(doP, doR, idx, key);
    waitDone(0, 0, 0, lat);
  endtask

  task automatic waitIdx(input logic [3:0] target);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (rd_idx === target) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_rd_idx", {127'd0, found}, 128'd1);
  endtask

  initial begin
    int lat;
    logic [74:0] mTlbr;
    logic        mP;
    logic [3:0]  mPidx;
    logic [70:0] newEntry;

    rst = 1'b1; op_tlbp = 1'b0; op_tlbr = 1'b0; tlbwi = 1'b0;
    index_in = '0; probe_vpn2 = '0;
    for (int i = 0; i < 16; i++) mem[i] = mkEntry(i, 19'h10000 + 19'(3 * i));
    mem[3] = mkEntry(3, 19'h12345);
    mem[9] = mkEntry(9, 19'h12345);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    check("rst_rd_idx", {124'd0, rd_idx}, 128'd0);
    check("rst_tlbr_data", {53'd0, tlbr_data}, 128'd0);
    check("rst_probe_p", {127'd0, probe_p}, 128'd0);
    check("rst_probe_index", {124'd0, probe_index}, 128'd0);
    rst = 1'b0;

    vecs[0] = '{1'b0, 1'b1, 4'd5,  19'h0,     2,  {mkEntry(5, 19'h1000F), 4'd5},  1'b0, 4'd0};
    vecs[1] = '{1'b1, 1'b0, 4'd0,  19'h12345, 5,  {mkEntry(5, 19'h1000F), 4'd5},  1'b0, 4'd3};
    vecs[2] = '{1'b1, 1'b0, 4'd0,  19'h7FFFF, 17, {mkEntry(5, 19'h1000F), 4'd5},  1'b1, 4'd3};
    vecs[3] = '{1'b0, 1'b1, 4'd15, 19'h0,     2,  {mkEntry(15, 19'h1002D), 4'd15}, 1'b1, 4'd3};
    vecs[4] = '{1'b1, 1'b0, 4'd0,  19'h1002D, 17, {mkEntry(15, 19'h1002D), 4'd15}, 1'b0, 4'd15};
    vecs[5] = '{1'b1, 1'b0, 4'd0,  19'h10000, 2,  {mkEntry(15, 19'h1002D), 4'd15}, 1'b0, 4'd0};
    vecs[6] = '{1'b0, 1'b1, 4'd0,  19'h0,     2,  {mkEntry(0, 19'h10000), 4'd0},  1'b0, 4'd0};
    vecs[7] = '{1'b1, 1'b1, 4'd7,  19'h12345, 5,  {mkEntry(0, 19'h10000), 4'd0},  1'b0, 4'd3};

    for (int i = 0; i < 8; i++) begin
      runOp(vecs[i].doP, vecs[i].doR, vecs[i].idx, vecs[i].key, lat);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(vecs[i].lat));
      check($sformatf("vec%0d_tlbr_data", i), {53'd0, tlbr_data}, {53'd0, vecs[i].expTlbr});
      check($sformatf("vec%0d_probe_p", i), {127'd0, probe_p}, {127'd0, vecs[i].expP});
      check($sformatf("vec%0d_probe_index", i), {124'd0, probe_index}, {124'd0, vecs[i].expPidx});
      checkIdleAfter();
    end

    // Ops pulsed while busy are ignored: the miss probe runs to the end untouched.
    startOp(1'b1, 1'b0, 4'd0, 19'h7FFFF);
    waitDone(0, 2, 5, lat);
    check("repulse_latency", 128'(lat), 128'd17);
    check("repulse_probe_p", {127'd0, probe_p}, 128'd1);
    check("repulse_tlbr_data", {53'd0, tlbr_data}, {53'd0, mkEntry(0, 19'h10000), 4'd0});
    checkIdleAfter();

    // Write into the entry being read: the read retries and returns the new data.
    newEntry = 71'h55_AAAA_5555_AAAA_5555;
    startOp(1'b0, 1'b1, 4'd4, 19'h0);
    @(negedge clk);
    mem[4] = newEntry;
    tlbwi  = 1'b1;
    @(posedge clk);
    #1 tlbwi = 1'b0;
    waitDone(1, 0, 0, lat);
    check("wr_read_latency", 128'(lat), 128'd3);
    check("wr_read_tlbr_data", {53'd0, tlbr_data}, {53'd0, newEntry, 4'd4});
    check("wr_read_probe_p", {127'd0, probe_p}, 128'd1);
    checkIdleAfter();

    // Write during a scan restarts it at index 0 with the latched key.
    startOp(1'b1, 1'b0, 4'd0, 19'h00ABC);
    waitIdx(4'd6);
    mem[2][70:52] = 19'h00ABC;
    tlbwi = 1'b1;
    @(posedge clk);
    #1 tlbwi = 1'b0;
    @(negedge clk);
    check("wr_scan_restart_idx", {124'd0, rd_idx}, 128'd0);
    waitDone(1, 0, 0, lat);
    check("wr_scan_latency", 128'(lat), 128'd4);
    check("wr_scan_probe_index", {124'd0, probe_index}, 128'd2);
    check("wr_scan_probe_p", {127'd0, probe_p}, 128'd0);
    checkIdleAfter();

    // Reset in the middle of a scan aborts with no done pulse.
    startOp(1'b1, 1'b0, 4'd0, 19'h7FFFF);
    waitIdx(4'd7);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("abort_done", {127'd0, done}, 128'd0);
      check("abort_busy", {127'd0, busy}, 128'd0);
    end
    check("abort_rd_idx", {124'd0, rd_idx}, 128'd0);
    check("abort_tlbr_data", {53'd0, tlbr_data}, 128'd0);
    check("abort_probe_p", {127'd0, probe_p}, 128'd0);
    check("abort_probe_index", {124'd0, probe_index}, 128'd0);

    runOp(1'b0, 1'b1, 4'd9, 19'h0, lat);
    check("post_rst_latency", 128'(lat), 128'd2);
    check("post_rst_tlbr_data", {53'd0, tlbr_data}, {53'd0, mem[9], 4'd9});
    checkIdleAfter();
    mTlbr = {mem[9], 4'd9};
    mP    = 1'b0;
    mPidx = 4'd0;

    // Randomized ops against the array model: reads return the addressed entry,
    // probes report the lowest index whose VPN2 equals the key.
    for (int t = 0; t < 40; t++) begin
      int kind, expLat, hitIdx;
      logic [3:0]  idx;
      logic [18:0] key;
      for (int i = 0; i < 16; i++)
        mem[i] = {19'($urandom_range(1, 24)), 52'({$urandom(), $urandom()})};
      kind   = $urandom_range(0, 2);
      idx    = 4'($urandom_range(0, 15));
      key    = 19'($urandom_range(1, 6));
      hitIdx = -1;
      if (kind == 0) begin
        expLat = 2;
        mTlbr  = {mem[idx], idx};
      end else begin
        for (int i = 0; i < 16; i++)
          if (hitIdx < 0 && mem[i][70:52] == key) hitIdx = i;
        if (hitIdx >= 0) begin
          expLat = 2 + hitIdx;
          mP     = 1'b0;
          mPidx  = 4'(hitIdx);
        end else begin
          expLat = NUM_ENTRIES + 1;
          mP     = 1'b1;
        end
      end
      runOp(kind != 0, kind != 1, idx, key, lat);
      check($sformatf("rnd%0d_latency", t), 128'(lat), 128'(expLat));
      check($sformatf("rnd%0d_tlbr_data", t), {53'd0, tlbr_data}, {53'd0, mTlbr});
      check($sformatf("rnd%0d_probe_p", t), {127'd0, probe_p}, {127'd0, mP});
      check($sformatf("rnd%0d_probe_index", t), {124'd0, probe_index}, {124'd0, mPidx});
      checkIdleAfter();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
